// File: rtl/rpm_div_scheduler.sv
// Shared RPM engine: round-robin arbiter feeding one multiplier and a bit-serial restoring divider.
// Optional sticky request-overrun flags are built when RPM_DIV_SCHEDULER_OVERRUN_EN is defined.
//
// state | meaning
// IDLE  | waiting; grants the next pending channel at or after rr_ptr
// MUL   | dividend = m0 * RPM_K
// DIV   | one quotient bit per cycle, PROD_W cycles
// OUT   | result held on rpm_*_o until the consumer accepts it
module rpm_div_scheduler #(
    parameter int N_CH       = 4,
    parameter int M0_W       = 16,
    parameter int M1_W       = 32,
    parameter int DATA_WIDTH = 16,
    parameter int RPM_K      = 367647,
    parameter int PROD_W     = 36
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_CH-1:0]            meas_valid_i,
    input  logic [N_CH*M0_W-1:0]       meas_m0_i,
    input  logic [N_CH*M1_W-1:0]       meas_m1_i,
    input  logic [N_CH-1:0]            meas_dir_i,
    output logic                       rpm_valid_o,
    input  logic                       rpm_ready_i,
    output logic [DATA_WIDTH-1:0]      rpm_data_o,
    output logic [$clog2(N_CH)-1:0]    rpm_ch_o,
    output logic                       busy_o
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
    ,
    output logic [N_CH-1:0]            overrun_o,
    input  logic [N_CH-1:0]            overrun_clr_i
`endif
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(PROD_W);
    localparam logic [PROD_W-1:0]     K_EXT    = PROD_W'(RPM_K);
    localparam logic [DATA_WIDTH-2:0] MAG_MAX  = '1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PROD_W - 1);
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

    state_t state, state_nxt;

    logic [M0_W-1:0] slot_m0  [N_CH];
    logic [M1_W-1:0] slot_m1  [N_CH];
    logic [N_CH-1:0] slot_dir;
    logic [N_CH-1:0] pending;
    logic [CH_W-1:0] rr_ptr;

    logic            grant_hit;
    logic [CH_W-1:0] grant_idx;
    logic            grant;
    logic [N_CH-1:0] grant_vec;

    logic [M0_W-1:0]   op_m0;
    logic [M1_W-1:0]   op_m1;
    logic              op_dir;
    logic [CH_W-1:0]   op_ch;
    logic [PROD_W-1:0] qr;
    logic [M1_W-1:0]   rem;
    logic [CNT_W-1:0]  cnt;

    logic [M1_W:0]           shifted;
    logic                    q_bit;
    logic [M1_W-1:0]         rem_nxt;
    logic [PROD_W-1:0]       q_final;
    logic [DATA_WIDTH-2:0]   mag;
    logic [DATA_WIDTH-1:0]   mag_ext;
    logic [DATA_WIDTH-1:0]   fmt;

    // Round-robin search starting at rr_ptr, wrapping modulo N_CH.
    always_comb begin
        int idx;
        logic [CH_W-1:0] sel;
        idx       = 0;
        sel       = '0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            sel = idx[CH_W-1:0];
            if (!grant_hit && pending[sel]) begin
                grant_hit = 1'b1;
                grant_idx = sel;
            end
        end
    end

    assign grant = (state == IDLE) && grant_hit;

    always_comb begin
        grant_vec = '0;
        if (grant) grant_vec[grant_idx] = 1'b1;
    end

    // A new strobe in the grant cycle re-arms pending; the engine takes the old slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending  <= '0;
            slot_dir <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_m0[i] <= '0;
                slot_m1[i] <= '0;
            end
        end else begin
            pending <= (pending & ~grant_vec) | meas_valid_i;
            for (int i = 0; i < N_CH; i++) begin
                if (meas_valid_i[i]) begin
                    slot_m0[i]  <= meas_m0_i[i*M0_W +: M0_W];
                    slot_m1[i]  <= meas_m1_i[i*M1_W +: M1_W];
                    slot_dir[i] <= meas_dir_i[i];
                end
            end
            if (grant) rr_ptr <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_hit) state_nxt = MUL;
            MUL:  state_nxt = DIV;
            DIV:  if (cnt == CNT_LAST) state_nxt = OUT;
            OUT:  if (rpm_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state != IDLE);
        rpm_valid_o = (state == OUT);
    end

    // Restoring step; the low M1_W bits of the subtraction are exact whenever it is taken.
    always_comb begin
        shifted = {rem, qr[PROD_W-1]};
        q_bit   = (shifted >= {1'b0, op_m1});
        rem_nxt = q_bit ? (shifted[M1_W-1:0] - op_m1) : shifted[M1_W-1:0];
        q_final = {qr[PROD_W-2:0], q_bit};
        if ((op_m1 == '0) || (q_final > PROD_W'(MAG_MAX))) mag = MAG_MAX;
        else                                                 mag = q_final[DATA_WIDTH-2:0];
        mag_ext = {1'b0, mag};
        fmt     = op_dir ? (DATA_WIDTH'(0) - mag_ext) : mag_ext;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_m0      <= '0;
            op_m1      <= '0;
            op_dir     <= 1'b0;
            op_ch      <= '0;
            qr         <= '0;
            rem        <= '0;
            cnt        <= '0;
            rpm_data_o <= '0;
            rpm_ch_o   <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    op_m0  <= slot_m0[grant_idx];
                    op_m1  <= slot_m1[grant_idx];
                    op_dir <= slot_dir[grant_idx];
                    op_ch  <= grant_idx;
                end
                MUL: begin
                    qr  <= PROD_W'(op_m0) * K_EXT;
                    rem <= '0;
                    cnt <= '0;
                end
                DIV: begin
                    qr  <= q_final;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rpm_data_o <= fmt;
                        rpm_ch_o   <= op_ch;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) overrun_o <= '0;
        else       overrun_o <= (overrun_o & ~overrun_clr_i) | (meas_valid_i & pending & ~grant_vec);
    end
`endif

endmodule

// File: tb/tb_rpm_div_scheduler.sv
// Directed bench for rpm_div_scheduler: latency, formatting, arbitration, backpressure and reset abort.
// Overrun flags are checked when RPM_DIV_SCHEDULER_OVERRUN_EN is defined.
module tb_rpm_div_scheduler;

    localparam int N_CH = 4;
    localparam int M0_W = 16;
    localparam int M1_W = 32;
    localparam int DW   = 16;

    logic                   clk;
    logic                   rstn;
    logic [N_CH-1:0]        meas_valid;
    logic [N_CH*M0_W-1:0]   m0_bus;
    logic [N_CH*M1_W-1:0]   m1_bus;
    logic [N_CH-1:0]        dir_bus;
    logic                   rpm_valid_o;
    logic                   rpm_ready;
    logic [DW-1:0]          rpm_data_o;
    logic [1:0]             rpm_ch_o;
    logic                   busy_o;
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
    logic [N_CH-1:0]        overrun_o;
    logic [N_CH-1:0]        overrun_clr;
`endif

    int vectors;
    int miscompares;

    rpm_div_scheduler dut (
        .clk          (clk),
        .rstn         (rstn),
        .meas_valid_i (meas_valid),
        .meas_m0_i    (m0_bus),
        .meas_m1_i    (m1_bus),
        .meas_dir_i   (dir_bus),
        .rpm_valid_o  (rpm_valid_o),
        .rpm_ready_i  (rpm_ready),
        .rpm_data_o   (rpm_data_o),
        .rpm_ch_o     (rpm_ch_o),
        .busy_o       (busy_o)
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
        ,
        .overrun_o    (overrun_o),
        .overrun_clr_i(overrun_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [15:0] m0, input logic [31:0] m1, input logic dir);
        m0_bus[ch*M0_W +: M0_W] = m0;
        m1_bus[ch*M1_W +: M1_W] = m1;
        dir_bus[ch]             = dir;
    endtask

    task automatic strobe(input logic [N_CH-1:0] mask);
        meas_valid = mask;
        @(posedge clk); #1;
        meas_valid = '0;
    endtask

    // Waits (bounded) for valid; returns the number of edges waited.
    task automatic wait_result(input string tag, output int n);
        n = 0;
        while (!rpm_valid_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, {31'd0, rpm_valid_o}, 32'd1);
    endtask

    task automatic consume();
        rpm_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] data, input logic [1:0] ch,
                                 input int lat);
        int n;
        wait_result(tag, n);
        if (lat >= 0) check({tag, "_lat"}, n, lat);
        check({tag, "_data"}, {16'd0, rpm_data_o}, {16'd0, data});
        check({tag, "_ch"}, {30'd0, rpm_ch_o}, {30'd0, ch});
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        meas_valid  = '0;
        m0_bus      = '0;
        m1_bus      = '0;
        dir_bus     = '0;
        rpm_ready   = 1'b1;
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
        overrun_clr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rpm_valid_o}, 32'd0);
        check("rst_data", {16'd0, rpm_data_o}, 32'd0);
        check("rst_ch", {30'd0, rpm_ch_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Basic forward, latency 38 edges after capture
        set_ch(0, 16'd4, 32'd10000, 1'b0);
        strobe(4'b0001);
        expect_result("ch0_fwd", 16'h0093, 2'd0, 38);
        check("idle_valid", {31'd0, rpm_valid_o}, 32'd0);
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // Reverse; flipping the dir port after capture must not matter
        set_ch(2, 16'd4, 32'd5000, 1'b1);
        strobe(4'b0100);
        dir_bus[2] = 1'b0;
        expect_result("ch2_rev", 16'hFEDA, 2'd2, 38);

        set_ch(1, 16'd4, 32'd10, 1'b0);
        strobe(4'b0010);
        expect_result("sat_pos", 16'h7FFF, 2'd1, 38);
        set_ch(1, 16'd4, 32'd10, 1'b1);
        strobe(4'b0010);
        expect_result("sat_neg", 16'h8001, 2'd1, 38);
        set_ch(3, 16'd4, 32'd0, 1'b0);
        strobe(4'b1000);
        expect_result("m1_zero", 16'h7FFF, 2'd3, 38);
        set_ch(3, 16'd0, 32'd10000, 1'b1);
        strobe(4'b1000);
        expect_result("m0_zero", 16'h0000, 2'd3, 38);

        // Last grant was ch3, so rr_ptr is 0: all four come out in order, 39 cycles apart
        set_ch(0, 16'd4, 32'd10000, 1'b0);
        set_ch(1, 16'd4, 32'd5000, 1'b0);
        set_ch(2, 16'd4, 32'd2000, 1'b0);
        set_ch(3, 16'd4, 32'd1000, 1'b0);
        strobe(4'b1111);
        expect_result("rr_a0", 16'd147, 2'd0, 38);
        expect_result("rr_a1", 16'd294, 2'd1, 38);
        expect_result("rr_a2", 16'd735, 2'd2, 38);
        expect_result("rr_a3", 16'd1470, 2'd3, 38);

        strobe(4'b1001);
        expect_result("rr_b0", 16'd147, 2'd0, 38);
        expect_result("rr_b3", 16'd1470, 2'd3, 38);

        // Backpressure with a ch1 overwrite while the engine is parked in OUT
        rpm_ready = 1'b0;
        set_ch(0, 16'd4, 32'd10000, 1'b0);
        strobe(4'b0001);
        begin
            int n;
            wait_result("bp", n);
            check("bp_lat", n, 38);
        end
        for (int i = 0; i < 50; i++) begin
            if (i == 5) begin
                set_ch(1, 16'd4, 32'd10000, 1'b0);
                meas_valid = 4'b0010;
            end
            if (i == 10) begin
                set_ch(1, 16'd8, 32'd10000, 1'b0);
                meas_valid = 4'b0010;
            end
            @(posedge clk); #1;
            meas_valid = '0;
            check("bp_hold", {13'd0, rpm_valid_o, rpm_data_o, rpm_ch_o}, {13'd0, 1'b1, 16'h0093, 2'd0});
        end
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
        check("ovr_set", {28'd0, overrun_o}, 32'h2);
        overrun_clr = 4'b0010;
        @(posedge clk); #1;
        overrun_clr = '0;
        check("ovr_clr", {28'd0, overrun_o}, 32'h0);
`endif
        consume();
        expect_result("bp_ch1", 16'd294, 2'd1, 38);

        // Reset during DIV with ch0 left pending
        set_ch(2, 16'd4, 32'd5000, 1'b1);
        strobe(4'b0100);
        repeat (5) @(posedge clk);
        #1;
        set_ch(0, 16'd4, 32'd10000, 1'b0);
        strobe(4'b0001);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, rpm_valid_o}, 32'd0);
        check("arst_data", {16'd0, rpm_data_o}, 32'd0);
        check("arst_ch", {30'd0, rpm_ch_o}, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
`ifdef RPM_DIV_SCHEDULER_OVERRUN_EN
        check("arst_ovr", {28'd0, overrun_o}, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {30'd0, busy_o, rpm_valid_o}, 32'd0);
        end
        set_ch(3, 16'd4, 32'd1000, 1'b0);
        strobe(4'b1000);
        expect_result("post_rst_ch3", 16'd1470, 2'd3, 38);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rpm_div_scheduler.md
Name: rpm_div_scheduler

Overview:
Shared RPM arithmetic engine for N encoder channels. Each channel front-end delivers one measurement window per request: a pulse count m0, a reference-tick count m1 and a direction bit. The block queues one pending request per channel and grants the channels round-robin to a single multiplier plus bit-serial divider, computing RPM = m0*RPM_K/m1. It returns a signed, saturated RPM sample with the channel id over a valid/ready handshake to the PID layer, so N full dividers are not needed.

Parameters:
N_CH, 4, number of encoder channels (2..8)
M0_W, 16, width of pulse count m0
M1_W, 32, width of reference-tick count m1
DATA_WIDTH, 16, signed RPM output width
RPM_K, 367647, scale constant (10 MHz * 60 / (408*4)); 20-bit unsigned
PROD_W, 36, product width, M0_W+20; also the number of divider iterations

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
meas_valid_i  in  N_CH  per-channel one-cycle request strobe
meas_m0_i  in  N_CH*M0_W  packed m0; channel i at [i*M0_W +: M0_W]
meas_m1_i  in  N_CH*M1_W  packed m1; channel i at [i*M1_W +: M1_W]
meas_dir_i  in  N_CH  direction; 0 forward, 1 reverse
rpm_valid_o  out  1  result valid
rpm_ready_i  in  1  consumer ready
rpm_data_o  out  DATA_WIDTH  signed RPM, two's complement
rpm_ch_o  out  clog2(N_CH)  channel id of the result
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: async, active-low (rstn), clock clk. All outputs clear to 0. Pending flags clear. RR pointer clears to 0. State goes to IDLE. Asserting reset mid-operation aborts it immediately; the in-flight result is discarded.
- Capture: on meas_valid_i[i] the channel latches m0, m1 and dir into its slot and sets pending[i].
  - A request on a channel already pending overwrites that slot; only the newest data is kept.
  - If a request arrives in the same cycle that channel is granted, the granted data goes to the engine and the new request re-sets pending (request wins).
- FSM IDLE -> MUL -> DIV -> OUT -> IDLE:
  - IDLE: if any pending bit is set, grant the first set channel at or after rr_ptr (wrapping). Copy its slot to the operand registers, clear its pending bit, set rr_ptr = granted+1 mod N_CH, go to MUL.
  - MUL: dividend = zero-extended m0 * RPM_K (PROD_W bits, exact, no truncation). Go to DIV with the iteration counter at 0.
  - DIV: restoring unsigned division, one quotient bit per cycle, MSB first, exactly PROD_W cycles. The divisor is m1 zero-extended. On the last iteration, load the output and go to OUT.
  - OUT: hold rpm_valid_o=1, rpm_data_o and rpm_ch_o stable until rpm_valid_o && rpm_ready_i. On that cycle drop valid and go to IDLE. No grant is made until the next IDLE cycle.
- Latency: with an idle engine, rpm_valid_o rises on the (PROD_W+2)th rising edge after the edge that captured the request. Throughput is one result per PROD_W+3 cycles when rpm_ready_i is held high.
- Output formatting:
  - Saturate the unsigned quotient magnitude to 2^(DATA_WIDTH-1)-1 (32767).
  - dir=1 negates the saturated magnitude; the range is symmetric, so -32768 never appears.
  - m1=0 bypasses the divide result and forces magnitude 32767, then applies the sign. The DIV state length is unchanged.
  - m0=0 gives 0 for either direction; no negative zero is possible.
- Direction and channel id travel with the operands, never with the live input ports.

Optional Feature:
RPM_DIV_SCHEDULER_OVERRUN_EN
- Defined: adds output overrun_o [N_CH] and input overrun_clr_i [N_CH].
  - overrun_o[i] sets sticky when meas_valid_i[i] arrives while pending[i]=1 and channel i is not granted that cycle.
  - Cleared by overrun_clr_i[i]; a set and clear in the same cycle leaves the bit set. Reset value 0.
- Undefined: both ports are absent and overwrites happen silently. Datapath timing is identical.

Test Plan:
- ch0 m0=4, m1=10000, dir=0 -> rpm_data_o=147 (0x0093), rpm_ch_o=0; valid rises exactly 38 edges after the capture edge.
- ch2 m0=4, m1=5000, dir=1 -> rpm_data_o=-294 (0xFEDA), rpm_ch_o=2.
- ch1 m0=4, m1=10, dir=0 -> 32767 (0x7FFF); same with dir=1 -> -32767 (0x8001); m1=0, dir=0 -> 0x7FFF; m0=0, dir=1 -> 0x0000.
- Arbitration:
  - Strobe all 4 channels in one cycle -> results in order ch0, ch1, ch2, ch3.
  - Then strobe ch0 and ch3 together -> ch0 first (rr_ptr wrapped to 0), then ch3.
- Backpressure: hold rpm_ready_i=0 for 50 cycles -> valid, data and ch stay stable. Meanwhile strobe ch1 twice (m0=4 then m0=8, m1=10000) -> the next ch1 result is 294; overrun_o[1]=1 when the feature is on.
- Assert rstn low during DIV -> all outputs 0 and pending cleared. After release, a fresh ch3 request produces a correct result with no stale output.
